bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter BIN_W, default 16, SHALL set the binary input width (legal range 1..32).
REQ-002 Parameter DIGITS, default 5, SHALL set the number of BCD output digits (legal range 1..10).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 in_valid  input  1  SHALL indicate that bin carries a conversion request.
REQ-006 in_ready  output  1  SHALL indicate that the block can accept a request.
REQ-007 bin  input  BIN_W  SHALL be the unsigned binary value to convert.
REQ-008 out_valid  output  1  SHALL indicate that the result outputs are valid.
REQ-009 out_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-010 bcd  output  4*DIGITS  SHALL carry packed BCD, with digit 0 (ones) in bits [3:0].
REQ-011 overflow  output  1  SHALL flag that the value did not fit in DIGITS digits.
REQ-012 lz_mask  output  DIGITS  SHALL mark leading-zero digits (bit k=1 means digit k is blanked).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 In IDLE, in_ready=1; in every other state, in_ready=0.
REQ-015 On in_valid&&in_ready, the block SHALL latch bin into a shift register, clear the digit accumulators and overflow, load the bit counter with BIN_W, and enter SHIFT.
REQ-016 Each SHIFT cycle SHALL perform one double-dabble step: add 3 to every digit >=5, then shift {digits, shift-register} left by one bit, bringing in the MSB of the shift register.
REQ-017 A 1 shifted out of the top digit's bit 3 in any step SHALL set the sticky overflow; that bit is discarded, so bcd = value mod 10^DIGITS.
REQ-018 After exactly BIN_W SHIFT cycles, the FSM SHALL enter DONE with out_valid=1.
REQ-019 Latency: for a handshake at edge T, out_valid SHALL rise at edge T+BIN_W+1.
REQ-020 In DONE, bcd, overflow and lz_mask SHALL remain stable until out_valid&&out_ready.
REQ-021 On out_valid&&out_ready, the FSM SHALL return to IDLE, giving in_ready=1 on the next cycle; there is no same-cycle accept/complete overlap.
REQ-022 Throughput SHALL be one conversion per BIN_W+2 cycles with out_ready held at 1.
REQ-023 lz_mask bit k (k>=1) SHALL be 1 iff digits k..DIGITS-1 are all zero; bit 0 SHALL always be 0.
REQ-024 lz_mask SHALL be computed from the registered bcd and is valid only when out_valid=1.
REQ-025 Input changes outside the accept cycle SHALL NOT affect an in-flight conversion.
REQ-026 in_valid while not in IDLE SHALL be ignored; no request is queued.
REQ-027 BIN_W=1 SHALL work, giving a single SHIFT cycle.

Reset
REQ-028 While rst=1, the block SHALL be forced to IDLE and in_ready=1.
REQ-029 While rst=1, out_valid=0, bcd=0, overflow=0 and lz_mask={DIGITS-1{1'b1},1'b0}.
REQ-030 Asserting rst mid-SHIFT or in DONE SHALL abort and discard the conversion without producing an output.
REQ-031 The first accept after rst deasserts SHALL be possible on the first rising edge at which rst=0.

Verification
REQ-032 The bench SHALL cover: defaults, bin=65535, out_ready=1 -> out_valid at T+17, bcd=0x65535, overflow=0, lz_mask=5'b00000.
REQ-033 The bench SHALL cover: defaults, bin=0 -> bcd=0x00000, overflow=0, lz_mask=5'b11110.
REQ-034 The bench SHALL cover: DIGITS=4, bin=12345 -> bcd=0x2345, overflow=1; and bin=9999 -> bcd=0x9999, overflow=0.
REQ-035 The bench SHALL cover: bin=42 with out_ready=0 for 10 cycles -> bcd=0x00042 and lz_mask=5'b11100 stable, in_ready=0 throughout; accept then in_ready=1 on the next cycle.
REQ-036 The bench SHALL cover: rst pulsed at SHIFT cycle 8 of bin=1234 -> no out_valid, in_ready=1; a new bin=7 then yields bcd=0x00007.
REQ-037 The bench SHALL cover: a random sweep of 10^4 values across BIN_W in {1, 8, 16, 20} and DIGITS in {1, 3, 7}, compared against a div/mod reference model, including overflow, lz_mask and latency.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock, valid/ready on both sides.
// Digits that do not fit are dropped, so bcd is the value mod 10^DIGITS with a sticky overflow flag.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow,
    output logic [DIGITS-1:0]   lz_mask
);

    localparam int unsigned CW = $clog2(BIN_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [BIN_W-1:0]    sr_q, sr_d;
    logic [4*DIGITS-1:0] dig_q, dig_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] dig_shift;
    logic                carry;

    // One double-dabble step: correct digits >= 5, then shift the next binary bit in.
    always_comb begin
        adj = dig_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (dig_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = dig_q[4*d +: 4] + 4'd3;
            end
        end
        dig_shift = {adj[4*DIGITS-2:0], sr_q[BIN_W-1]};
        carry     = adj[4*DIGITS-1];
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = bin;
                    dig_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_q << 1;
                dig_d = dig_shift;
                ovf_d = ovf_q | carry;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Digit k is blanked only when it and every digit above it are zero; the ones digit always shows.
    always_comb begin
        logic zero_run;
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_run   = zero_run & (dig_q[4*k +: 4] == 4'd0);
            lz_mask[k] = zero_run;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd       = dig_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and swept checks of bin2bcd_seq: reset, latency, hold, abort, truncation and a
// div/mod reference across several width/digit combinations.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Default-parameter instance
    logic        in_valid = 1'b0;
    logic [15:0] bin      = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] bcd;
    logic        overflow;
    logic [4:0]  lz_mask;

    bin2bcd_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bcd      (bcd),
        .overflow (overflow),
        .lz_mask  (lz_mask)
    );

    // Four-digit instance for truncation
    logic        d4_in_valid = 1'b0;
    logic [15:0] d4_bin      = '0;
    logic        d4_in_ready;
    logic        d4_out_valid;
    logic        d4_out_ready = 1'b1;
    logic [15:0] d4_bcd;
    logic        d4_overflow;
    logic [3:0]  d4_lz;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (d4_in_valid),
        .in_ready (d4_in_ready),
        .bin      (d4_bin),
        .out_valid(d4_out_valid),
        .out_ready(d4_out_ready),
        .bcd      (d4_bcd),
        .overflow (d4_overflow),
        .lz_mask  (d4_lz)
    );

    // Sweep instances: BIN_W in {1,8,16,20} x DIGITS in {1,3,7}, index g = gi*3 + gj
    logic        sw_in_valid [12];
    logic [31:0] sw_bin      [12];
    logic        sw_in_ready [12];
    logic        sw_out_valid[12];
    logic        sw_overflow [12];
    logic [39:0] sw_bcd      [12];
    logic [9:0]  sw_lz       [12];
    logic        sw_out_ready = 1'b1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bw
        for (genvar gj = 0; gj < 3; gj++) begin : g_dg
            localparam int BW = (gi == 0) ? 1 : (gi == 1) ? 8 : (gi == 2) ? 16 : 20;
            localparam int DG = (gj == 0) ? 1 : (gj == 1) ? 3 : 7;
            wire [4*DG-1:0] b;
            wire [DG-1:0]   lz;
            bin2bcd_seq #(.BIN_W(BW), .DIGITS(DG)) u_sw (
                .clk      (clk),
                .rst      (rst),
                .in_valid (sw_in_valid[gi*3+gj]),
                .in_ready (sw_in_ready[gi*3+gj]),
                .bin      (sw_bin[gi*3+gj][BW-1:0]),
                .out_valid(sw_out_valid[gi*3+gj]),
                .out_ready(sw_out_ready),
                .bcd      (b),
                .overflow (sw_overflow[gi*3+gj]),
                .lz_mask  (lz)
            );
            assign sw_bcd[gi*3+gj] = 40'(b);
            assign sw_lz[gi*3+gj]  = 10'(lz);
        end
    end

    function automatic int bw_of(input int g);
        case (g / 3)
            0:       return 1;
            1:       return 8;
            2:       return 16;
            default: return 20;
        endcase
    endfunction

    function automatic int dg_of(input int g);
        case (g % 3)
            0:       return 1;
            1:       return 3;
            default: return 7;
        endcase
    endfunction

    // Reference: repeated div/mod by 10, overflow when anything is left over.
    function automatic void ref_model(input longint v, input int dg, output logic [39:0] b,
                                      output logic ov, output logic [9:0] lz);
        longint r = v;
        logic   zr = 1'b1;
        b = '0;
        for (int i = 0; i < dg; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        ov = (r != 0);
        lz = '0;
        for (int k = dg - 1; k >= 1; k--) begin
            zr    = zr & (b[4*k +: 4] == 4'd0);
            lz[k] = zr;
        end
    endfunction

    // From the negedge after the accept edge T, returns the edge offset at which out_valid is
    // first sampled high (-1 if it never rises).
    task automatic wait_main(output int rise);
        rise = -1;
        for (int e = 0; e < 40; e++) begin
            if (out_valid === 1'b1) begin
                rise = e + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic start_main(input logic [15:0] v, output int rise);
        @(negedge clk);
        bin      = v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        bin      = ~v;
        wait_main(rise);
    endtask

    task automatic test_reset();
        int rise;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (bcd !== 20'h0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_bcd: got %h/%b want 00000/0", bcd, overflow);
        end
        vectors++;
        if (lz_mask !== 5'b11110) begin
            miscompares++;
            $display("FAIL reset_lz: got %b want 11110", lz_mask);
        end
        // Accept must be possible on the very first edge after release.
        bin      = 16'd5;
        in_valid = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_main(rise);
        vectors++;
        if (rise != 17 || bcd !== 20'h00005) begin
            miscompares++;
            $display("FAIL first_accept: got rise %0d bcd %h want 17 00005", rise, bcd);
        end
        @(negedge clk);
    endtask

    task automatic test_max();
        int rise;
        out_ready = 1'b1;
        start_main(16'd65535, rise);
        vectors++;
        if (rise != 17) begin
            miscompares++;
            $display("FAIL max_latency: got %0d want 17", rise);
        end
        vectors++;
        if (bcd !== 20'h65535 || overflow !== 1'b0 || lz_mask !== 5'b00000) begin
            miscompares++;
            $display("FAIL max_value: got %h/%b/%b want 65535/0/00000", bcd, overflow, lz_mask);
        end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL max_return: got rdy %b vld %b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero();
        int rise;
        start_main(16'd0, rise);
        vectors++;
        if (rise != 17 || bcd !== 20'h00000 || overflow !== 1'b0 || lz_mask !== 5'b11110) begin
            miscompares++;
            $display("FAIL zero: got %0d %h/%b/%b want 17 00000/0/11110",
                     rise, bcd, overflow, lz_mask);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int rise;
        out_ready = 1'b0;
        start_main(16'd42, rise);
        vectors++;
        if (rise != 17) begin
            miscompares++;
            $display("FAIL hold_latency: got %0d want 17", rise);
        end
        // A request during DONE must be ignored.
        in_valid = 1'b1;
        bin      = 16'd999;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (bcd !== 20'h00042 || lz_mask !== 5'b11100 || in_ready !== 1'b0 ||
                out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_c%0d: got %h/%b rdy %b vld %b want 00042/11100 0 1",
                         c, bcd, lz_mask, in_ready, out_valid);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 20'h00042) begin
            miscompares++;
            $display("FAIL hold_release: got rdy %b vld %b bcd %h want 1 0 00042",
                     in_ready, out_valid, bcd);
        end
    endtask

    task automatic test_back_to_back();
        int acc1 = -1;
        int acc2 = -1;
        out_ready = 1'b1;
        @(negedge clk);
        bin      = 16'd500;
        in_valid = 1'b1;
        for (int e = 0; e < 60; e++) begin
            if (in_ready === 1'b1) begin
                if (acc1 < 0) begin
                    acc1 = e;
                end else begin
                    acc2 = e;
                    break;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (acc1 < 0 || acc2 < 0 || acc2 - acc1 != 18) begin
            miscompares++;
            $display("FAIL throughput: got accepts %0d,%0d want spacing 18", acc1, acc2);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int rise;
        int seen = 0;
        @(negedge clk);
        bin      = 16'd1234;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pre: got rdy %b vld %b want 0 0", in_ready, out_valid);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 20'h0) begin
            miscompares++;
            $display("FAIL abort_rst: got rdy %b vld %b bcd %h want 1 0 00000",
                     in_ready, out_valid, bcd);
        end
        #1 rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d valid cycles rdy %b want 0 1", seen, in_ready);
        end
        start_main(16'd7, rise);
        vectors++;
        if (rise != 17 || bcd !== 20'h00007 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_next: got %0d %h/%b want 17 00007/0", rise, bcd, overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_digits4();
        logic [15:0] vin [2] = '{16'd12345, 16'd9999};
        logic [15:0] vexp[2] = '{16'h2345, 16'h9999};
        logic        vov [2] = '{1'b1, 1'b0};
        int rise;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d4_bin      = vin[i];
            d4_in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            d4_in_valid = 1'b0;
            rise = -1;
            for (int e = 0; e < 40; e++) begin
                if (d4_out_valid === 1'b1) begin
                    rise = e + 1;
                    break;
                end
                @(negedge clk);
            end
            vectors++;
            if (rise != 17 || d4_bcd !== vexp[i] || d4_overflow !== vov[i] || d4_lz !== 4'b0000)
            begin
                miscompares++;
                $display("FAIL d4_%0d: got %0d %h/%b/%b want 17 %h/%b/0000",
                         vin[i], rise, d4_bcd, d4_overflow, d4_lz, vexp[i], vov[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] v   [12];
        int          rise[12];
        logic [39:0] eb;
        logic        eov;
        logic [9:0]  elz;
        int          done;
        for (int it = 0; it < 834; it++) begin
            @(negedge clk);
            for (int g = 0; g < 12; g++) begin
                logic [31:0] m = (32'd1 << bw_of(g)) - 32'd1;
                if (it == 0)      v[g] = m;
                else if (it == 1) v[g] = '0;
                else              v[g] = $urandom & m;
                sw_bin[g]      = v[g];
                sw_in_valid[g] = 1'b1;
                rise[g]        = -1;
            end
            @(posedge clk);
            @(negedge clk);
            for (int g = 0; g < 12; g++) begin
                sw_in_valid[g] = 1'b0;
                sw_bin[g]      = $urandom;
            end
            for (int e = 0; e < 30; e++) begin
                done = 0;
                for (int g = 0; g < 12; g++) begin
                    if (rise[g] < 0 && sw_out_valid[g] === 1'b1) begin
                        rise[g] = e + 1;
                        ref_model(longint'(v[g]), dg_of(g), eb, eov, elz);
                        vectors++;
                        if (sw_bcd[g] !== eb || sw_overflow[g] !== eov || sw_lz[g] !== elz ||
                            rise[g] != bw_of(g) + 1) begin
                            miscompares++;
                            $display("FAIL sweep_w%0d_d%0d_v%0d: got %h/%b/%b lat %0d want %h/%b/%b lat %0d",
                                     bw_of(g), dg_of(g), v[g], sw_bcd[g], sw_overflow[g],
                                     sw_lz[g], rise[g], eb, eov, elz, bw_of(g) + 1);
                        end
                    end
                    if (rise[g] >= 0) done++;
                end
                if (done == 12) break;
                @(negedge clk);
            end
            for (int g = 0; g < 12; g++) begin
                if (rise[g] < 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sweep_timeout_w%0d_d%0d: got no out_valid want one",
                             bw_of(g), dg_of(g));
                end
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 12; g++) begin
            sw_in_valid[g] = 1'b0;
            sw_bin[g]      = '0;
        end
        test_reset();
        test_max();
        test_zero();
        test_hold();
        test_back_to_back();
        test_abort();
        test_digits4();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
